data_connect_fifo_pipe: RTL and testbench

//  Parametrised valid/ready decoupling stage for the SPI-flash datapath: a DEPTH-entry circular buffer between an upstream producer and a downstream consumer.

---
 rtl/data_pipe_pkg.sv | 18 +
 rtl/data_pipe_ptr_ctrl.sv | 151 +++++++++++++++
 rtl/data_connect_fifo_pipe.sv | 90 +++++++++
 tb/tb_data_connect_fifo_pipe.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/data_pipe_pkg.sv
// Shared types and helpers for the data_connect_fifo_pipe decoupling stage.
package data_pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_FULL   = 2'd2
    } pipe_state_e;

    localparam int MODE_HANDSHAKE = 0;
    localparam int MODE_PUSH      = 1;

    // Occupancy counter width: must hold the value DEPTH itself.
    function automatic int clog2_cnt(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/data_pipe_ptr_ctrl.sv
// Pointer, occupancy and FSM control for the circular buffer; all status
// outputs are registered so no combinational path crosses the stage.
module data_pipe_ptr_ctrl
    import data_pipe_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int AF_LEVEL  = 3,
    parameter int PUSH_MODE = MODE_HANDSHAKE
) (
    input  logic                         clock,
    input  logic                         rst,
    input  logic                         clk_en,
    input  logic                         flush,
    input  logic                         from_up_vld,
    input  logic                         from_down_ready,
    output logic                         to_up_ready,
    output logic                         to_down_vld,
    output logic [clog2_cnt(DEPTH)-1:0]  count,
    output logic                         almost_full,
    output logic                         over_flow,
    output logic                         wr_en,
    output logic [$clog2(DEPTH)-1:0]     wr_ptr,
    output logic [$clog2(DEPTH)-1:0]     head_ptr_nxt,
    output logic                         head_vld_nxt,
    output logic                         head_bypass
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = clog2_cnt(DEPTH);

    pipe_state_e   state_q, state_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ready_q, ready_d;
    logic          vld_q, vld_d;
    logic          af_q, af_d;
    logic          ovf_q, ovf_d;

    logic full, pop, push, flush_en, push_eff, pop_eff;

    always_comb begin
        full     = (state_q == ST_FULL);
        flush_en = flush & clk_en;
        pop      = vld_q & from_down_ready & clk_en;
        if (PUSH_MODE == MODE_PUSH) begin
            push = from_up_vld & clk_en & (~full | pop);
        end else begin
            push = from_up_vld & clk_en & ready_q;
        end
        push_eff = push & ~flush_en;
        pop_eff  = pop & ~flush_en;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (flush_en) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_eff) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop_eff)  rd_ptr_d = rd_ptr_q + PW'(1);
            if (push_eff && !pop_eff) begin
                count_d = count_q + CW'(1);
            end else if (pop_eff && !push_eff) begin
                count_d = count_q - CW'(1);
            end
            // A push-only producer writing into a full buffer loses its word.
            if ((PUSH_MODE == MODE_PUSH) && from_up_vld && clk_en && full && !pop) begin
                ovf_d = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush_en) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (push_eff) state_d = ST_ACTIVE;
                end
                ST_ACTIVE: begin
                    if (push_eff && !pop_eff && count_q == CW'(DEPTH - 1)) begin
                        state_d = ST_FULL;
                    end else if (pop_eff && !push_eff && count_q == CW'(1)) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (pop_eff && !push_eff) state_d = ST_ACTIVE;
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_comb begin
        ready_d = ready_q;
        vld_d   = vld_q;
        af_d    = af_q;
        if (clk_en) begin
            ready_d = (state_d != ST_FULL);
            vld_d   = (state_d != ST_EMPTY);
            af_d    = (count_d >= CW'(AF_LEVEL));
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q  <= ST_EMPTY;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b0;
            vld_q    <= 1'b0;
            af_q     <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ready_q  <= ready_d;
            vld_q    <= vld_d;
            af_q     <= af_d;
            ovf_q    <= ovf_d;
        end
    end

    // The head register is loaded from the write port when the new head is
    // the word being written this cycle (buffer was empty).
    always_comb begin
        to_up_ready  = ready_q;
        to_down_vld  = vld_q;
        count        = count_q;
        almost_full  = af_q;
        over_flow    = ovf_q;
        wr_en        = push_eff;
        wr_ptr       = wr_ptr_q;
        head_ptr_nxt = rd_ptr_d;
        head_vld_nxt = vld_d;
        head_bypass  = push_eff && (wr_ptr_q == rd_ptr_d);
    end

endmodule

// File: rtl/data_connect_fifo_pipe.sv
// DEPTH-entry valid/ready decoupling buffer: storage array plus registered
// head-data output; control lives in data_pipe_ptr_ctrl.
module data_connect_fifo_pipe
    import data_pipe_pkg::*;
#(
    parameter int DSIZE     = 8,
    parameter int DEPTH     = 4,
    parameter int AF_LEVEL  = 3,
    parameter int PUSH_MODE = MODE_HANDSHAKE
) (
    input  logic                         clock,
    input  logic                         rst,
    input  logic                         clk_en,
    input  logic                         flush,
    input  logic                         from_up_vld,
    input  logic [DSIZE-1:0]             from_up_data,
    output logic                         to_up_ready,
    input  logic                         from_down_ready,
    output logic                         to_down_vld,
    output logic [DSIZE-1:0]             to_down_data,
    output logic [clog2_cnt(DEPTH)-1:0]  count,
    output logic                         almost_full,
    output logic                         over_flow
);

    localparam int PW = $clog2(DEPTH);

    logic             wr_en;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    head_ptr_nxt;
    logic             head_vld_nxt;
    logic             head_bypass;

    logic [DSIZE-1:0] mem_q [DEPTH];
    logic [DSIZE-1:0] data_q, data_d;

    data_pipe_ptr_ctrl #(
        .DEPTH     (DEPTH),
        .AF_LEVEL  (AF_LEVEL),
        .PUSH_MODE (PUSH_MODE)
    ) u_ctrl (
        .clock           (clock),
        .rst             (rst),
        .clk_en          (clk_en),
        .flush           (flush),
        .from_up_vld     (from_up_vld),
        .from_down_ready (from_down_ready),
        .to_up_ready     (to_up_ready),
        .to_down_vld     (to_down_vld),
        .count           (count),
        .almost_full     (almost_full),
        .over_flow       (over_flow),
        .wr_en           (wr_en),
        .wr_ptr          (wr_ptr),
        .head_ptr_nxt    (head_ptr_nxt),
        .head_vld_nxt    (head_vld_nxt),
        .head_bypass     (head_bypass)
    );

    // Storage is deliberately not reset; validity is tracked by the control.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[wr_ptr] <= from_up_data;
        end
    end

    always_comb begin
        data_d = data_q;
        if (clk_en) begin
            if (!head_vld_nxt) begin
                data_d = '0;
            end else if (head_bypass) begin
                data_d = from_up_data;
            end else begin
                data_d = mem_q[head_ptr_nxt];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign to_down_data = data_q;

endmodule

// File: tb/tb_data_connect_fifo_pipe.sv
// Self-checking bench: a handshake instance and a push-only instance share
// stimulus and are compared every cycle against a queue-based reference.
module tb_data_connect_fifo_pipe;

    logic       clock = 1'b0;
    logic       rst, clk_en, flush, up_vld, down_ready;
    logic [7:0] up_data;

    logic       h_ready, h_vld, h_af, h_ovf;
    logic [7:0] h_data;
    logic [2:0] h_count;
    logic       p_ready, p_vld, p_af, p_ovf;
    logic [7:0] p_data;
    logic [2:0] p_count;

    int  n_checks = 0;
    int  n_fail   = 0;

    int  mq[2][$];
    bit  m_rdy[2];
    bit  m_ovf[2];

    always #5 clock = ~clock;

    data_connect_fifo_pipe #(.DSIZE(8), .DEPTH(4), .AF_LEVEL(3), .PUSH_MODE(0)) u_hs (
        .clock(clock), .rst(rst), .clk_en(clk_en), .flush(flush),
        .from_up_vld(up_vld), .from_up_data(up_data), .to_up_ready(h_ready),
        .from_down_ready(down_ready), .to_down_vld(h_vld), .to_down_data(h_data),
        .count(h_count), .almost_full(h_af), .over_flow(h_ovf)
    );

    data_connect_fifo_pipe #(.DSIZE(8), .DEPTH(4), .AF_LEVEL(3), .PUSH_MODE(1)) u_pm (
        .clock(clock), .rst(rst), .clk_en(clk_en), .flush(flush),
        .from_up_vld(up_vld), .from_up_data(up_data), .to_up_ready(p_ready),
        .from_down_ready(down_ready), .to_down_vld(p_vld), .to_down_data(p_data),
        .count(p_count), .almost_full(p_af), .over_flow(p_ovf)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Reference: the buffer is an ordered queue of at most 4 words.
    task automatic modelStep(input int m);
        bit full, pop, push;
        if (rst) begin
            mq[m].delete();
            m_rdy[m] = 1'b0;
            m_ovf[m] = 1'b0;
        end else if (clk_en) begin
            full = (mq[m].size() == 4);
            pop  = (mq[m].size() > 0) && down_ready;
            if (flush) begin
                mq[m].delete();
            end else begin
                push = up_vld && ((m == 1) ? (!full || pop) : m_rdy[m]);
                if (m == 1 && up_vld && full && !pop) m_ovf[m] = 1'b1;
                if (pop) void'(mq[m].pop_front());
                if (push) mq[m].push_back(int'(up_data));
            end
            m_rdy[m] = (mq[m].size() < 4);
        end
    endtask

    task automatic checkDut(input int m, input string pfx, input logic rdy, input logic vld,
                            input logic [7:0] data, input logic [2:0] cnt,
                            input logic af, input logic ovf);
        int sz;
        sz = mq[m].size();
        checkOutput({pfx, ".ready"}, 32'(rdy), 32'(m_rdy[m]));
        checkOutput({pfx, ".vld"},   32'(vld), 32'(sz > 0));
        checkOutput({pfx, ".data"},  32'(data), (sz > 0) ? 32'(mq[m][0] & 8'hFF) : 32'd0);
        checkOutput({pfx, ".count"}, 32'(cnt), 32'(sz));
        checkOutput({pfx, ".af"},    32'(af),  32'(sz >= 3));
        checkOutput({pfx, ".ovf"},   32'(ovf), 32'(m_ovf[m]));
    endtask

    task automatic applyStimulus(input bit r, input bit en, input bit fl, input bit v,
                                 input logic [7:0] d, input bit dr);
        rst        = r;
        clk_en     = en;
        flush      = fl;
        up_vld     = v;
        up_data    = d;
        down_ready = dr;
        @(posedge clock);
        modelStep(0);
        modelStep(1);
        @(negedge clock);
        checkDut(0, "hs", h_ready, h_vld, h_data, h_count, h_af, h_ovf);
        checkDut(1, "pm", p_ready, p_vld, p_data, p_count, p_af, p_ovf);
    endtask

    initial begin
        logic [7:0] burst [3];
        burst[0] = 8'h11; burst[1] = 8'h22; burst[2] = 8'h33;

        applyStimulus(1, 1, 0, 0, 8'h00, 0);
        applyStimulus(1, 1, 0, 0, 8'h00, 0);
        applyStimulus(0, 1, 0, 0, 8'h00, 1);

        $display("[TB] streaming three words through with downstream ready");
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 1, burst[i], 1);
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 0, 8'h00, 1);

        $display("[TB] filling against a stalled consumer, then draining");
        for (int i = 0; i < 5; i++) applyStimulus(0, 1, 0, 1, 8'(8'h41 + i), 0);
        for (int i = 0; i < 6; i++) applyStimulus(0, 1, 0, 0, 8'h00, 1);

        $display("[TB] full buffer with simultaneous push/pop, then push without pop");
        for (int i = 0; i < 4; i++) applyStimulus(0, 1, 0, 1, 8'(8'h60 + i), 0);
        applyStimulus(0, 1, 0, 1, 8'h70, 1);
        applyStimulus(0, 1, 0, 1, 8'h71, 1);
        applyStimulus(0, 1, 0, 1, 8'h72, 0);
        applyStimulus(0, 1, 0, 1, 8'h73, 0);
        for (int i = 0; i < 6; i++) applyStimulus(0, 1, 0, 0, 8'h00, 1);

        $display("[TB] toggling clk_en with valid and ready held");
        for (int i = 0; i < 10; i++) applyStimulus(0, i[0] == 1'b0, 0, 1, 8'(8'h80 + i), 1);
        for (int i = 0; i < 4; i++) applyStimulus(0, 1, 0, 0, 8'h00, 1);

        $display("[TB] flush with a same-cycle push");
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 1, 8'(8'h90 + i), 0);
        applyStimulus(0, 1, 1, 1, 8'hAA, 1);
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 0, 8'h00, 1);

        $display("[TB] reset during a burst, then a long wrapping burst");
        for (int i = 0; i < 2; i++) applyStimulus(0, 1, 0, 1, 8'(8'hB0 + i), 0);
        applyStimulus(1, 1, 0, 1, 8'hB2, 0);
        applyStimulus(0, 1, 0, 1, 8'h01, 1);
        applyStimulus(0, 1, 0, 1, 8'h02, 1);
        for (int i = 0; i < 12; i++) applyStimulus(0, 1, 0, 1, 8'(8'hC0 + i), (i % 3) != 2);
        for (int i = 0; i < 6; i++) applyStimulus(0, 1, 0, 0, 8'h00, 1);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 600; i++) begin
            applyStimulus($urandom_range(0, 99) == 0,
                          $urandom_range(0, 7) != 0,
                          $urandom_range(0, 24) == 0,
                          $urandom_range(0, 3) != 0,
                          8'($urandom),
                          $urandom_range(0, 2) != 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
